// File: rtl/dmem_arbiter_if.sv
// Cache/memory bus seen by the dcache/icache arbiter: both cache request ports,
// the memory command/response/tag-return port and the per-cache return ports.
interface dmem_arbiter_if #(
    parameter int XLEN = 32
);
    // Handshake: a nonzero *2mem_command is a request held until a nonzero
    // response (the tag) accepts it in the same cycle; a nonzero *_tag marks
    // that cycle's data as valid for that tag.
    logic [1:0]      dcache2mem_command;
    logic [XLEN-1:0] dcache2mem_addr;
    logic [63:0]     dcache2mem_data;
    logic [1:0]      icache2mem_command;
    logic [XLEN-1:0] icache2mem_addr;

    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;

    logic [3:0]      mem2dcache_response;
    logic [63:0]     mem2dcache_data;
    logic [3:0]      mem2dcache_tag;
    logic [3:0]      mem2icache_response;
    logic [63:0]     mem2icache_data;
    logic [3:0]      mem2icache_tag;

    // The arbiter side.
    modport slave (
        input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
        input  icache2mem_command, icache2mem_addr,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2dcache_response, mem2dcache_data, mem2dcache_tag,
        output mem2icache_response, mem2icache_data, mem2icache_tag
    );

    // The caches and memory together, as seen from the arbiter's environment.
    modport master (
        output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
        output icache2mem_command, icache2mem_addr,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2dcache_response, mem2dcache_data, mem2dcache_tag,
        input  mem2icache_response, mem2icache_data, mem2icache_tag
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port memory arbiter: dcache-priority grant with icache anti-starvation,
// a tag owner table, and steering of returned load tags back to the owning cache.
module dmem_arbiter #(
    parameter int  XLEN         = 32,
    parameter int  STARVE_LIMIT = 4,
    parameter int  NUM_TAGS     = 16,
    localparam int CNT_W        = $clog2(NUM_TAGS + 1),
    localparam int STV_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic             clock,
    input  logic             reset,
    dmem_arbiter_if.slave    bus,
    output logic             dcache_grant,
    output logic             icache_grant,
    output logic [CNT_W-1:0] outstanding_count,
    output logic             orphan_err,
    output logic [STV_W-1:0] dbg_starve_cnt
);
    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;

    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;   // 0 dcache, 1 icache
    logic [STV_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                orphan_q, orphan_d;

    logic dcache_req;
    logic icache_req;
    logic starve_hit;
    logic accepted;
    logic alloc;
    logic ret_valid;
    logic ret_owner;

    // Grant: dcache first unless icache has waited STARVE_LIMIT accepted grants.
    always_comb begin
        dcache_req   = bus.dcache2mem_command != CMD_NONE;
        icache_req   = bus.icache2mem_command == CMD_LOAD;
        starve_hit   = icache_req && (starve_cnt_q == STV_W'(STARVE_LIMIT));
        icache_grant = icache_req && (!dcache_req || starve_hit);
        dcache_grant = dcache_req && !icache_grant;
    end

    always_comb begin
        bus.proc2mem_command = CMD_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        if (dcache_grant) begin
            bus.proc2mem_command = bus.dcache2mem_command;
            bus.proc2mem_addr    = bus.dcache2mem_addr;
            bus.proc2mem_data    = bus.dcache2mem_data;
        end else if (icache_grant) begin
            bus.proc2mem_command = CMD_LOAD;
            bus.proc2mem_addr    = bus.icache2mem_addr;
        end
    end

    always_comb begin
        bus.mem2dcache_response = dcache_grant ? bus.mem2proc_response : 4'd0;
        bus.mem2icache_response = icache_grant ? bus.mem2proc_response : 4'd0;
    end

    // Tag return is looked up in the table as it stood before this edge.
    always_comb begin
        ret_valid           = (bus.mem2proc_tag != 4'd0) && valid_q[bus.mem2proc_tag];
        ret_owner           = owner_q[bus.mem2proc_tag];
        bus.mem2dcache_tag  = (ret_valid && !ret_owner) ? bus.mem2proc_tag : 4'd0;
        bus.mem2icache_tag  = (ret_valid &&  ret_owner) ? bus.mem2proc_tag : 4'd0;
        bus.mem2dcache_data = bus.mem2proc_data;
        bus.mem2icache_data = bus.mem2proc_data;
    end

    always_comb begin
        accepted = bus.mem2proc_response != 4'd0;
        alloc    = accepted &&
                   ((dcache_grant && bus.dcache2mem_command == CMD_LOAD) || icache_grant);

        valid_d = valid_q;
        owner_d = owner_q;
        if (bus.mem2proc_tag != 4'd0) begin
            valid_d[bus.mem2proc_tag] = 1'b0;
        end
        // Allocation after the free so a reused tag stays live with its new owner.
        if (alloc) begin
            valid_d[bus.mem2proc_response] = 1'b1;
            owner_d[bus.mem2proc_response] = icache_grant;
        end

        orphan_d = orphan_q || ((bus.mem2proc_tag != 4'd0) && !valid_q[bus.mem2proc_tag]);

        starve_cnt_d = starve_cnt_q;
        if ((icache_grant && accepted) || !icache_req) begin
            starve_cnt_d = '0;
        end else if (dcache_grant && accepted && (starve_cnt_q != STV_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + STV_W'(1);
        end

        count_d = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q      <= '0;
            owner_q      <= '0;
            starve_cnt_q <= '0;
            count_q      <= '0;
            orphan_q     <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            count_q      <= count_d;
            orphan_q     <= orphan_d;
        end
    end

    assign outstanding_count = count_q;
    assign orphan_err        = orphan_q;
    assign dbg_starve_cnt    = starve_cnt_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed grant/forwarding checks and a scoreboard of
// accepted loads whose tag returns are popped and checked for correct steering.
module tb_dmem_arbiter;
  localparam int XLEN = 32;
  localparam int W = 70;  // {owner[1:0] (0 d, 1 i, 2 orphan), tag[3:0], data[63:0]}
  localparam logic [1:0] NONE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] STORE = 2'd2;

  logic clock;
  logic reset;
  logic dcache_grant;
  logic icache_grant;
  logic [4:0] outstanding_count;
  logic orphan_err;
  logic [2:0] dbg_starve_cnt;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  dmem_arbiter_if #(.XLEN(XLEN)) bus ();

  dmem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .dcache_grant(dcache_grant),
    .icache_grant(icache_grant),
    .outstanding_count(outstanding_count),
    .orphan_err(orphan_err),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // driver: new inputs at the falling edge, outputs settle 1 time unit later
  task automatic drive(input logic [1:0] dcmd, input logic [31:0] daddr, input logic [63:0] ddata,
                       input logic [1:0] icmd, input logic [31:0] iaddr,
                       input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rdata);
    @(negedge clock);
    bus.dcache2mem_command = dcmd;
    bus.dcache2mem_addr = daddr;
    bus.dcache2mem_data = ddata;
    bus.icache2mem_command = icmd;
    bus.icache2mem_addr = iaddr;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag = tag;
    bus.mem2proc_data = rdata;
    #1;
  endtask

  task automatic idle();
    drive(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, 4'd0, 64'h0);
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic expect_ret(input logic [1:0] owner, input logic [3:0] tag, input logic [63:0] data);
    exp_q.push_back({owner, tag, data});
  endtask

  task automatic check_routing(input logic [W-1:0] e);
    logic [3:0] t;
    t = e[67:64];
    check("ret_dcache_tag", 64'(bus.mem2dcache_tag), (e[69:68] == 2'd0) ? 64'(t) : 64'd0);
    check("ret_icache_tag", 64'(bus.mem2icache_tag), (e[69:68] == 2'd1) ? 64'(t) : 64'd0);
    check("ret_dcache_data", bus.mem2dcache_data, e[63:0]);
    check("ret_icache_data", bus.mem2icache_data, e[63:0]);
  endtask

  // scoreboard: memory returns the oldest expected tag, routing is checked
  task automatic ret_next();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
      drive(NONE, 32'h0, 64'h0, NONE, 32'h0, 4'd0, e[67:64], e[63:0]);
      check_routing(e);
    end
  endtask

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [W-1:0] e;
    logic [63:0] d;
    reset = 1'b1;
    idle();
    idle();
    // combinational paths follow inputs in reset, but nothing is allocated
    drive(LOAD, 32'h100, 64'h0, NONE, 32'h0, 4'd3, 4'd0, 64'h0);
    check("reset_comb_dgrant", 64'(dcache_grant), 64'd1);
    check("reset_comb_dresp", 64'(bus.mem2dcache_response), 64'd3);
    idle();
    reset = 1'b0;
    idle();
    check("rst_count", 64'(outstanding_count), 64'd0);
    check("rst_orphan", 64'(orphan_err), 64'd0);
    check("rst_starve", 64'(dbg_starve_cnt), 64'd0);
    check("rst_grants", 64'({dcache_grant, icache_grant}), 64'd0);
    check("rst_cmd", 64'(bus.proc2mem_command), 64'd0);
    check("rst_addr", 64'(bus.proc2mem_addr), 64'd0);

    // lone dcache load
    drive(LOAD, 32'h100, 64'h0, NONE, 32'h0, 4'd3, 4'd0, 64'h0);
    check("t1_dgrant", 64'(dcache_grant), 64'd1);
    check("t1_igrant", 64'(icache_grant), 64'd0);
    check("t1_cmd", 64'(bus.proc2mem_command), 64'd1);
    check("t1_addr", 64'(bus.proc2mem_addr), 64'h100);
    check("t1_dresp", 64'(bus.mem2dcache_response), 64'd3);
    check("t1_iresp", 64'(bus.mem2icache_response), 64'd0);
    expect_ret(2'd0, 4'd3, 64'hDEADBEEF);
    idle();
    check("t1_count1", 64'(outstanding_count), 64'd1);
    ret_next();
    idle();
    check("t1_count0", 64'(outstanding_count), 64'd0);

    // both request together: dcache wins
    drive(LOAD, 32'h140, 64'h0, LOAD, 32'h800, 4'd5, 4'd0, 64'h0);
    check("t2_dgrant", 64'(dcache_grant), 64'd1);
    check("t2_igrant", 64'(icache_grant), 64'd0);
    check("t2_addr", 64'(bus.proc2mem_addr), 64'h140);
    check("t2_dresp", 64'(bus.mem2dcache_response), 64'd5);
    check("t2_iresp", 64'(bus.mem2icache_response), 64'd0);
    expect_ret(2'd0, 4'd5, rand64());
    idle();
    check("t2_count1", 64'(outstanding_count), 64'd1);
    ret_next();
    idle();
    check("t2_count0", 64'(outstanding_count), 64'd0);

    // starvation: four dcache grants, then icache
    for (int i = 0; i < 4; i++) begin
      drive(LOAD, 32'h1000 + 32'(i * 8), 64'h0, LOAD, 32'h2000, 4'(10 + i), 4'd0, 64'h0);
      check("t3_dgrant", 64'(dcache_grant), 64'd1);
      check("t3_igrant", 64'(icache_grant), 64'd0);
      check("t3_starve", 64'(dbg_starve_cnt), 64'(i));
      expect_ret(2'd0, 4'(10 + i), rand64());
    end
    drive(LOAD, 32'h1020, 64'hFFFF_FFFF_FFFF_FFFF, LOAD, 32'h2000, 4'd14, 4'd0, 64'h0);
    check("t3_igrant5", 64'(icache_grant), 64'd1);
    check("t3_dgrant5", 64'(dcache_grant), 64'd0);
    check("t3_starve5", 64'(dbg_starve_cnt), 64'd4);
    check("t3_addr5", 64'(bus.proc2mem_addr), 64'h2000);
    check("t3_data5", bus.proc2mem_data, 64'h0);
    check("t3_iresp5", 64'(bus.mem2icache_response), 64'd14);
    check("t3_dresp5", 64'(bus.mem2dcache_response), 64'd0);
    expect_ret(2'd1, 4'd14, rand64());
    drive(LOAD, 32'h1028, 64'h0, LOAD, 32'h2000, 4'd0, 4'd0, 64'h0);
    check("t3_starve_clr", 64'(dbg_starve_cnt), 64'd0);
    check("t3_dgrant_back", 64'(dcache_grant), 64'd1);
    check("t3_count5", 64'(outstanding_count), 64'd5);
    idle();
    while (exp_q.size() > 0) ret_next();
    idle();
    check("t3_count0", 64'(outstanding_count), 64'd0);

    // dcache store: forwarded data, no allocation
    drive(STORE, 32'h200, 64'h1122334455667788, NONE, 32'h0, 4'd7, 4'd0, 64'h0);
    check("t4_cmd", 64'(bus.proc2mem_command), 64'd2);
    check("t4_addr", 64'(bus.proc2mem_addr), 64'h200);
    check("t4_data", bus.proc2mem_data, 64'h1122334455667788);
    check("t4_dresp", 64'(bus.mem2dcache_response), 64'd7);
    idle();
    check("t4_count", 64'(outstanding_count), 64'd0);

    // icache retries after two rejections
    for (int i = 0; i < 2; i++) begin
      drive(NONE, 32'h0, 64'h0, LOAD, 32'h400, 4'd0, 4'd0, 64'h0);
      check("t5_igrant", 64'(icache_grant), 64'd1);
      check("t5_cmd", 64'(bus.proc2mem_command), 64'd1);
      check("t5_iresp", 64'(bus.mem2icache_response), 64'd0);
    end
    drive(NONE, 32'h0, 64'h0, LOAD, 32'h400, 4'd9, 4'd0, 64'h0);
    check("t5_count_pre", 64'(outstanding_count), 64'd0);
    check("t5_iresp9", 64'(bus.mem2icache_response), 64'd9);
    expect_ret(2'd1, 4'd9, rand64());
    idle();
    check("t5_count1", 64'(outstanding_count), 64'd1);
    ret_next();
    idle();
    check("t5_count0", 64'(outstanding_count), 64'd0);

    // same tag freed (dcache) and reallocated (icache) in one cycle
    drive(LOAD, 32'h300, 64'h0, NONE, 32'h0, 4'd6, 4'd0, 64'h0);
    expect_ret(2'd0, 4'd6, rand64());
    idle();
    e = exp_q.pop_front();
    drive(NONE, 32'h0, 64'h0, LOAD, 32'h500, 4'd6, 4'd6, e[63:0]);
    check_routing(e);
    check("t6_igrant", 64'(icache_grant), 64'd1);
    expect_ret(2'd1, 4'd6, rand64());
    idle();
    check("t6_count", 64'(outstanding_count), 64'd1);
    ret_next();
    idle();
    check("t6_count0", 64'(outstanding_count), 64'd0);
    check("t6_orphan", 64'(orphan_err), 64'd0);

    // reset with loads in flight: returned tag is an orphan
    drive(LOAD, 32'h600, 64'h0, NONE, 32'h0, 4'd2, 4'd0, 64'h0);
    drive(LOAD, 32'h608, 64'h0, NONE, 32'h0, 4'd4, 4'd0, 64'h0);
    idle();
    check("t7_count2", 64'(outstanding_count), 64'd2);
    reset = 1'b1;
    idle();
    reset = 1'b0;
    d = rand64();
    exp_q.delete();
    expect_ret(2'd2, 4'd2, d);
    ret_next();
    check("t7_count_rst", 64'(outstanding_count), 64'd0);
    idle();
    check("t7_orphan", 64'(orphan_err), 64'd1);
    check("t7_count0", 64'(outstanding_count), 64'd0);
    idle();
    check("t7_orphan_sticky", 64'(orphan_err), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Single-port memory arbiter between the dcache, the icache and the shared tag-based memory model.
- Each cycle it grants at most one requester the memory command port.
- It records which requester owns every outstanding load tag.
- Returned data tags are steered back only to the owning cache.
- The dcache has priority, with a starvation counter that guarantees icache forward progress.

Parameters:
- XLEN, 32, address width.
- STARVE_LIMIT, 4, consecutive accepted dcache grants, while icache is requesting, after which icache gets priority.
- NUM_TAGS, 16, tag space size; tag 0 means "none".

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- dcache2mem_command  input  2  0 NONE, 1 LOAD, 2 STORE
- dcache2mem_addr  input  XLEN  dcache request address
- dcache2mem_data  input  64  dcache store data
- icache2mem_command  input  2  0 NONE or 1 LOAD; 2 is treated as NONE
- icache2mem_addr  input  XLEN  icache request address
- mem2proc_response  input  4  nonzero when the memory accepts the command; value is the tag
- mem2proc_data  input  64  returned load data
- mem2proc_tag  input  4  nonzero when mem2proc_data is valid for that tag
- proc2mem_command  output  2  granted command
- proc2mem_addr  output  XLEN  granted address
- proc2mem_data  output  64  granted store data
- mem2dcache_response  output  4  response forwarded to dcache
- mem2dcache_data  output  64  returned data to dcache
- mem2dcache_tag  output  4  returned tag to dcache
- mem2icache_response  output  4  response forwarded to icache
- mem2icache_data  output  64  returned data to icache
- mem2icache_tag  output  4  returned tag to icache
- dcache_grant  output  1  dcache owns the port this cycle
- icache_grant  output  1  icache owns the port this cycle
- outstanding_count  output  5  number of valid owner-table entries
- orphan_err  output  1  sticky: a returned tag had no owner

Behaviour:
- Grant logic is combinational from the requests and the starvation state.
  - Default: dcache wins if its command is nonzero; otherwise icache wins if its command is LOAD.
  - If starve_cnt == STARVE_LIMIT and icache is requesting, icache wins.
  - Grants are one-hot or both zero.
- Request forwarding:
  - proc2mem_* carries the granted requester's fields.
  - With no grant: command is NONE, addr is 0, data is 0.
  - proc2mem_data is 0 for icache grants.
- Response forwarding is combinational.
  - mem2proc_response goes only to the granted side's *_response; the other side sees 0.
  - A response of 0 means the memory rejected the command. The requester holds its command and retries; the arbiter grants again by the same rules.
- Owner table: NUM_TAGS entries, each holding valid and owner (0 dcache, 1 icache).
  - An entry is allocated at the posedge where a LOAD is granted and mem2proc_response != 0, at index mem2proc_response.
  - STOREs never allocate.
  - An entry is freed at the posedge where mem2proc_tag equals its index.
  - Same tag freed and allocated in the same cycle: allocation wins and the entry stays valid with the new owner.
- Tag return is combinational.
  - If mem2proc_tag != 0 and the entry is valid: drive mem2<owner>_tag = mem2proc_tag; the other side gets tag 0.
  - mem2dcache_data and mem2icache_data always equal mem2proc_data; validity is carried by the tag alone.
  - If the entry is invalid: both sides see tag 0 and orphan_err sets at the next posedge, staying set until reset.
- starve_cnt (0..STARVE_LIMIT) updates at the posedge:
  - Resets to 0 when icache is granted with a nonzero response, or when icache is not requesting.
  - Increments, saturating, when dcache is granted with a nonzero response while icache is requesting.
  - Otherwise holds.
- outstanding_count equals the popcount of valid entries and updates at the posedge.
- Reset (including mid-transaction) has the following effects:
  - Clears the table, starve_cnt, outstanding_count and orphan_err.
  - Tags returned after reset for pre-reset loads are orphans and set orphan_err.
  - Combinational outputs follow the inputs during reset, but no state updates.

Test Plan:
- Dcache LOAD 0x100 alone, response 3 → dcache_grant=1, mem2dcache_response=3, mem2icache_response=0. Next cycle outstanding_count=1. Tag 3 returned with data 0xDEADBEEF → mem2dcache_tag=3, mem2icache_tag=0, then count=0.
- Dcache and icache LOAD together, response 5 → dcache granted, icache sees response 0. Later tag 5 goes to dcache only.
- Dcache requests continuously, icache LOAD held, all responses nonzero → dcache granted 4 cycles, icache granted on the 5th cycle, starve_cnt back to 0.
- Dcache STORE 0x200 with data 0x1122334455667788, response 7 → proc2mem_data matches, outstanding_count stays 0.
- Icache LOAD with response 0 for 2 cycles, then 9 → no allocation until the third cycle. Tag 9 routes to icache.
- Two loads allocated (tags 2 and 4), reset asserted, then tag 2 returned → both sides see tag 0, orphan_err=1, count=0.
